hms_time_counter: RTL and testbench

HMS_TIME_COUNTER -- requirements
Module: hms_time_counter

---
 rtl/hms_time_counter_if.sv | 34 +++
 rtl/hms_time_counter.sv | 165 ++++++++++++++++
 tb/tb_hms_time_counter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hms_time_counter_if.sv
// Signal bundle for hms_time_counter: count/load controls in, BCD time and event pulses out.
// The master side drives the controls; the counter itself sits on the slave side.
interface hms_time_counter_if;
  logic       tick;
  logic       dir;
  logic       load;
  logic       load_sel;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       load_pm;
  logic       alarm_arm;

  logic [3:0] secslo;
  logic [3:0] secshi;
  logic [3:0] minslo;
  logic [3:0] minshi;
  logic [3:0] hrslo;
  logic [3:0] hrshi;
  logic       pm;
  logic       rollover;
  logic       alarm_hit;
  logic       load_err;

  modport master (
    output tick, dir, load, load_sel, load_hr, load_min, load_sec, load_pm, alarm_arm,
    input  secslo, secshi, minslo, minshi, hrslo, hrshi, pm, rollover, alarm_hit, load_err
  );

  modport slave (
    input  tick, dir, load, load_sel, load_hr, load_min, load_sec, load_pm, alarm_arm,
    output secslo, secshi, minslo, minshi, hrslo, hrshi, pm, rollover, alarm_hit, load_err
  );
endinterface

// File: rtl/hms_time_counter.sv
// Hours:minutes:seconds up/down counter with BCD readout, validated loads and an optional alarm.
// HOUR_MODE selects 24h (0..23) or 12h (1..12 plus AM/PM); only 12 and 24 are meaningful.
module hms_time_counter #(
  parameter int HOUR_MODE = 24,
  parameter bit ALARM_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  hms_time_counter_if.slave    bus
);

  localparam bit         MODE12 = (HOUR_MODE == 12);
  localparam logic [4:0] HR_RST = MODE12 ? 5'd12 : 5'd0;

  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       pm_q, pm_d;
  logic [4:0] alm_hr_q, alm_hr_d;
  logic [5:0] alm_min_q, alm_min_d;
  logic       alm_pm_q, alm_pm_d;
  logic       rollover_q, rollover_d;
  logic       alarm_hit_q, alarm_hit_d;
  logic       load_err_q, load_err_d;

  logic time_load, alm_load, hr_ok, time_ok, alm_ok;

  assign time_load = bus.load && !bus.load_sel;
  assign alm_load  = bus.load && bus.load_sel;
  assign hr_ok     = MODE12 ? (bus.load_hr != 5'd0 && bus.load_hr <= 5'd12)
                            : (bus.load_hr <= 5'd23);
  assign alm_ok    = hr_ok && (bus.load_min <= 6'd59);
  assign time_ok   = alm_ok && (bus.load_sec <= 6'd59);

  // Binary 0..59 to two BCD digits without a divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    if (v >= 6'd50)      tens = 4'd5;
    else if (v >= 6'd40) tens = 4'd4;
    else if (v >= 6'd30) tens = 4'd3;
    else if (v >= 6'd20) tens = 4'd2;
    else if (v >= 6'd10) tens = 4'd1;
    else                 tens = 4'd0;
    return {tens, 4'(v - 6'(tens) * 6'd10)};
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    pm_d        = pm_q;
    alm_hr_d    = alm_hr_q;
    alm_min_d   = alm_min_q;
    alm_pm_d    = alm_pm_q;
    rollover_d  = 1'b0;
    alarm_hit_d = 1'b0;
    load_err_d  = 1'b0;

    if (time_load) begin
      // A time load always swallows a coincident tick, accepted or not.
      if (time_ok) begin
        sec_d = bus.load_sec;
        min_d = bus.load_min;
        hr_d  = bus.load_hr;
        pm_d  = MODE12 ? bus.load_pm : 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.tick) begin
      if (!bus.dir) begin
        if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
        else begin
          sec_d = 6'd0;
          if (min_q != 6'd59) min_d = min_q + 6'd1;
          else begin
            min_d = 6'd0;
            if (MODE12) begin
              hr_d = (hr_q == 5'd12) ? 5'd1 : hr_q + 5'd1;
              if (hr_q == 5'd11) begin
                pm_d       = !pm_q;
                rollover_d = pm_q;
              end
            end else if (hr_q == 5'd23) begin
              hr_d       = 5'd0;
              rollover_d = 1'b1;
            end else begin
              hr_d = hr_q + 5'd1;
            end
          end
        end
      end else begin
        if (sec_q != 6'd0) sec_d = sec_q - 6'd1;
        else begin
          sec_d = 6'd59;
          if (min_q != 6'd0) min_d = min_q - 6'd1;
          else begin
            min_d = 6'd59;
            if (MODE12) begin
              hr_d = (hr_q == 5'd1) ? 5'd12 : hr_q - 5'd1;
              if (hr_q == 5'd12) begin
                pm_d       = !pm_q;
                rollover_d = !pm_q;
              end
            end else if (hr_q == 5'd0) begin
              hr_d       = 5'd23;
              rollover_d = 1'b1;
            end else begin
              hr_d = hr_q - 5'd1;
            end
          end
        end
      end
      // Only tick-driven updates can raise the alarm; it compares against the pre-edge alarm value.
      alarm_hit_d = ALARM_EN && bus.alarm_arm && (sec_d == 6'd0) && (min_d == alm_min_q) &&
                    (hr_d == alm_hr_q) && (!MODE12 || (pm_d == alm_pm_q));
    end

    if (alm_load && ALARM_EN) begin
      if (alm_ok) begin
        alm_hr_d  = bus.load_hr;
        alm_min_d = bus.load_min;
        alm_pm_d  = MODE12 ? bus.load_pm : 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hr_q        <= HR_RST;
      pm_q        <= 1'b0;
      alm_hr_q    <= HR_RST;
      alm_min_q   <= 6'd0;
      alm_pm_q    <= 1'b0;
      rollover_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      pm_q        <= pm_d;
      alm_hr_q    <= alm_hr_d;
      alm_min_q   <= alm_min_d;
      alm_pm_q    <= alm_pm_d;
      rollover_q  <= rollover_d;
      alarm_hit_q <= alarm_hit_d;
      load_err_q  <= load_err_d;
    end
  end

  assign {bus.secshi, bus.secslo} = to_bcd(sec_q);
  assign {bus.minshi, bus.minslo} = to_bcd(min_q);
  assign {bus.hrshi,  bus.hrslo}  = to_bcd({1'b0, hr_q});
  assign bus.pm        = pm_q;
  assign bus.rollover  = rollover_q;
  assign bus.alarm_hit = alarm_hit_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Scoreboard bench for hms_time_counter: a 24h and a 12h instance share clock and reset;
// stimulus pushes hand-computed expectations, a negedge monitor pops and compares them.
module tb_hms_time_counter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t q24[$];
  exp_t q12[$];

  hms_time_counter_if b24 ();
  hms_time_counter_if b12 ();

  hms_time_counter #(.HOUR_MODE(24), .ALARM_EN(1'b1)) u24 (.clk(clk), .reset(reset), .bus(b24.slave));
  hms_time_counter #(.HOUR_MODE(12), .ALARM_EN(1'b1)) u12 (.clk(clk), .reset(reset), .bus(b12.slave));

  // Observed word: hh mm ss digits, then {pm, rollover, alarm_hit, load_err}.
  logic [31:0] act24, act12;
  assign act24 = {4'h0, b24.hrshi, b24.hrslo, b24.minshi, b24.minslo, b24.secshi, b24.secslo,
                  b24.pm, b24.rollover, b24.alarm_hit, b24.load_err};
  assign act12 = {4'h0, b12.hrshi, b12.hrslo, b12.minshi, b12.minslo, b12.secshi, b12.secslo,
                  b12.pm, b12.rollover, b12.alarm_hit, b12.load_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pack(input int h, m, s, input logic p, r, a, e);
    return {4'h0, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), p, r, a, e};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q24.size() > 0 && q24[0].cyc == cyc) begin
      check({"h24_", q24[0].nm}, act24, q24[0].val);
      void'(q24.pop_front());
    end
    while (q12.size() > 0 && q12[0].cyc == cyc) begin
      check({"h12_", q12[0].nm}, act12, q12[0].val);
      void'(q12.pop_front());
    end
  end

  // One cycle of stimulus on the selected instance; the other instance is held idle.
  task automatic drive(input bit m12, input logic tk, dr, ld, sel, input int lh, lm, ls,
                       input logic lp, arm, input int eh, em, es, input logic ep, er, ea, ee,
                       input string nm);
    exp_t e;
    @(negedge clk);
    b24.tick = 1'b0; b24.dir = 1'b0; b24.load = 1'b0; b24.load_sel = 1'b0; b24.alarm_arm = 1'b0;
    b12.tick = 1'b0; b12.dir = 1'b0; b12.load = 1'b0; b12.load_sel = 1'b0; b12.alarm_arm = 1'b0;
    if (m12) begin
      b12.tick = tk; b12.dir = dr; b12.load = ld; b12.load_sel = sel; b12.alarm_arm = arm;
      b12.load_hr = 5'(lh); b12.load_min = 6'(lm); b12.load_sec = 6'(ls); b12.load_pm = lp;
    end else begin
      b24.tick = tk; b24.dir = dr; b24.load = ld; b24.load_sel = sel; b24.alarm_arm = arm;
      b24.load_hr = 5'(lh); b24.load_min = 6'(lm); b24.load_sec = 6'(ls); b24.load_pm = lp;
    end
    e.cyc = cyc + 1;
    e.val = pack(eh, em, es, ep, er, ea, ee);
    e.nm  = nm;
    if (m12) q12.push_back(e);
    else     q24.push_back(e);
  endtask

  task automatic idle(input bit m12, input int eh, em, es, input logic ep, input string nm);
    drive(m12, 0, 0, 0, 0, 0, 0, 0, 0, 0, eh, em, es, ep, 0, 0, 0, nm);
  endtask

  task automatic tk(input bit m12, input logic dr, arm, input int eh, em, es,
                    input logic ep, er, ea, input string nm);
    drive(m12, 1, dr, 0, 0, 0, 0, 0, 0, arm, eh, em, es, ep, er, ea, 0, nm);
  endtask

  task automatic ld(input bit m12, input logic sel, tick, input int lh, lm, ls, input logic lp,
                    input int eh, em, es, input logic ep, ee, input string nm);
    drive(m12, tick, 0, 1, sel, lh, lm, ls, lp, 1, eh, em, es, ep, 0, 0, ee, nm);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    b24.tick = 1'b0; b24.dir = 1'b0; b24.load = 1'b0; b24.load_sel = 1'b0; b24.alarm_arm = 1'b0;
    b24.load_hr = '0; b24.load_min = '0; b24.load_sec = '0; b24.load_pm = 1'b0;
    b12.tick = 1'b0; b12.dir = 1'b0; b12.load = 1'b0; b12.load_sel = 1'b0; b12.alarm_arm = 1'b0;
    b12.load_hr = '0; b12.load_min = '0; b12.load_sec = '0; b12.load_pm = 1'b0;

    // Reset state and release.
    idle(0, 0, 0, 0, 0, "rst_state");
    idle(1, 12, 0, 0, 0, "rst_state");
    reset = 1'b1;
    idle(0, 0, 0, 0, 0, "rst_release");

    // 24h wrap in both directions.
    ld(0, 0, 0, 23, 59, 58, 0, 23, 59, 58, 0, 0, "ld_235958");
    tk(0, 0, 0, 23, 59, 59, 0, 0, 0, "up_235959");
    tk(0, 0, 0, 0, 0, 0, 0, 1, 0, "wrap_up");
    idle(0, 0, 0, 0, 0, "wrap_pulse_end");
    tk(0, 1, 0, 23, 59, 59, 0, 1, 0, "wrap_down");
    tk(0, 0, 0, 0, 0, 0, 0, 1, 0, "wrap_up_again");
    ld(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 0, 0, "ld_100000");
    tk(0, 1, 0, 9, 59, 59, 0, 0, 0, "borrow_hr");

    // Rejected loads, load/tick collision, pm ignored in 24h.
    ld(0, 0, 0, 24, 0, 0, 0, 9, 59, 59, 0, 1, "bad_hr24");
    ld(0, 0, 1, 12, 60, 0, 0, 9, 59, 59, 0, 1, "bad_min_drops_tick");
    idle(0, 9, 59, 59, 0, "err_pulse_end");
    ld(0, 0, 1, 5, 6, 7, 0, 5, 6, 7, 0, 0, "ld_wins_tick");
    ld(0, 0, 0, 1, 2, 3, 1, 1, 2, 3, 0, 0, "pm_ignored");

    // Continuous ticking across a minute carry.
    ld(0, 0, 0, 0, 0, 57, 0, 0, 0, 57, 0, 0, "ld_000057");
    tk(0, 0, 0, 0, 0, 58, 0, 0, 0, "run_58");
    tk(0, 0, 0, 0, 0, 59, 0, 0, 0, "run_59");
    tk(0, 0, 0, 0, 1, 0, 0, 0, 0, "run_carry");
    tk(0, 0, 0, 0, 1, 1, 0, 0, 0, "run_01");

    // Alarm at 07:30.
    ld(0, 1, 1, 7, 30, 0, 0, 0, 1, 2, 0, 0, "alm_ld_with_tick");
    ld(0, 0, 0, 7, 29, 59, 0, 7, 29, 59, 0, 0, "ld_072959");
    tk(0, 0, 1, 7, 30, 0, 0, 0, 1, "alarm_hit");
    idle(0, 7, 30, 0, 0, "alarm_pulse_end");
    ld(0, 0, 0, 7, 29, 59, 0, 7, 29, 59, 0, 0, "ld_072959_b");
    tk(0, 0, 0, 7, 30, 0, 0, 0, 0, "alarm_disarmed");
    ld(0, 0, 0, 7, 30, 0, 0, 7, 30, 0, 0, 0, "alarm_on_load");
    ld(0, 1, 0, 24, 30, 0, 0, 7, 30, 0, 0, 1, "bad_alarm_ld");
    ld(0, 0, 0, 7, 30, 1, 0, 7, 30, 1, 0, 0, "ld_073001");
    tk(0, 1, 1, 7, 30, 0, 0, 0, 1, "alarm_hit_down");

    // Asynchronous reset between edges during an hour carry.
    ld(0, 0, 0, 12, 59, 59, 0, 12, 59, 59, 0, 0, "ld_125959");
    tk(0, 0, 0, 0, 0, 0, 0, 0, 0, "async_rst");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("h24_async_rst_now", act24, pack(0, 0, 0, 0, 0, 0, 0));
    check("h12_async_rst_now", act12, pack(12, 0, 0, 0, 0, 0, 0));
    idle(0, 0, 0, 0, 0, "rst_hold");
    reset = 1'b1;
    tk(0, 0, 0, 0, 0, 1, 0, 0, 0, "first_tick_after_rst");

    // 12h noon/midnight transitions.
    idle(1, 12, 0, 0, 0, "idle_start");
    ld(1, 0, 0, 11, 59, 59, 0, 11, 59, 59, 0, 0, "ld_1159_am");
    tk(1, 0, 0, 12, 0, 0, 1, 0, 0, "noon");
    ld(1, 0, 0, 11, 59, 59, 1, 11, 59, 59, 1, 0, "ld_1159_pm");
    tk(1, 0, 0, 12, 0, 0, 0, 1, 0, "midnight");
    idle(1, 12, 0, 0, 0, "midnight_pulse_end");
    ld(1, 0, 0, 12, 59, 59, 0, 12, 59, 59, 0, 0, "ld_1259");
    tk(1, 0, 0, 1, 0, 0, 0, 0, 0, "12_to_1");
    ld(1, 0, 0, 12, 0, 0, 0, 12, 0, 0, 0, 0, "ld_12_am");
    tk(1, 1, 0, 11, 59, 59, 1, 1, 0, "down_midnight");
    ld(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, "ld_01_pm");
    tk(1, 1, 0, 12, 59, 59, 1, 0, 0, "down_1_to_12");
    ld(1, 0, 0, 12, 0, 0, 1, 12, 0, 0, 1, 0, "ld_12_pm");
    tk(1, 1, 0, 11, 59, 59, 0, 0, 0, "down_noon");
    ld(1, 0, 0, 0, 10, 0, 0, 11, 59, 59, 0, 1, "bad_hr0");
    ld(1, 0, 0, 13, 0, 0, 0, 11, 59, 59, 0, 1, "bad_hr13");

    // 12h alarm must also match AM/PM.
    ld(1, 1, 0, 7, 30, 0, 1, 11, 59, 59, 0, 0, "alm_ld_pm");
    ld(1, 0, 0, 7, 29, 59, 0, 7, 29, 59, 0, 0, "ld_0729_am");
    tk(1, 0, 1, 7, 30, 0, 0, 0, 0, "alarm_wrong_half");
    ld(1, 0, 0, 7, 29, 59, 1, 7, 29, 59, 1, 0, "ld_0729_pm");
    tk(1, 0, 1, 7, 30, 0, 1, 0, 1, "alarm_hit_pm");
    idle(1, 7, 30, 0, 1, "alarm_pulse_end");

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(q24.size() + q12.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
